// File: rtl/kuz_pkg.sv
// Shared GF(2^8) arithmetic and constants for the Kuznyechik linear layer.
// The multiply is written generically so constant operands fold into XOR networks.
package kuz_pkg;

    localparam logic [8:0] GF_POLY = 9'h1C3;

    // Entry i is the coefficient applied to byte a_i (a15 is the top byte).
    localparam logic [15:0][7:0] L_COEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_INV = 1'b1
    } kuz_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } kuz_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    function automatic logic [7:0] l_form(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ gf_mul(a[8*i +: 8], L_COEF[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/kuz_r_step.sv
// One combinational R (forward) or R^-1 (inverse) step on a 128-bit block.
module kuz_r_step
    import kuz_pkg::*;
(
    input  kuz_mode_e    mode_i,
    input  logic [127:0] data_i,
    output logic [127:0] data_o
);

    logic [127:0] rot;
    logic [7:0]   l_fwd;
    logic [7:0]   l_inv;

    // Inverse feeds the form with (a14..a0, a15), i.e. the block rotated left by a byte.
    assign rot   = {data_i[119:0], data_i[127:120]};
    assign l_fwd = l_form(data_i);
    assign l_inv = l_form(rot);

    always_comb begin
        if (mode_i == MODE_INV) begin
            data_o = {data_i[119:0], l_inv};
        end else begin
            data_o = {l_fwd, data_i[127:8]};
        end
    end

endmodule

// File: rtl/l_transform_engine.sv
// Iterative L / L^-1 engine: 16 R-steps per block, ROUNDS_PER_CYCLE of them per clock,
// with a valid/ready handshake on both sides and back-to-back block acceptance.
module l_transform_engine
    import kuz_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N_ITER = 16 / ROUNDS_PER_CYCLE;
    localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    kuz_state_e       state_q, state_d;
    logic [127:0]     data_q, data_d;
    kuz_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [127:0] chain [ROUNDS_PER_CYCLE+1];

    assign chain[0] = data_q;

    generate
        for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_step
            kuz_r_step u_step (
                .mode_i (mode_q),
                .data_i (chain[gi]),
                .data_o (chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_RUN: begin
                busy   = 1'b1;
                data_d = chain[ROUNDS_PER_CYCLE];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new block overrides the DONE->IDLE move, giving back-to-back operation.
        if (in_valid && in_ready) begin
            data_d  = in_data;
            mode_d  = kuz_mode_e'(in_mode);
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= MODE_FWD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_l_transform_engine.sv
// Bench for l_transform_engine: three engines (1, 4, 16 rounds per cycle) share stimulus,
// each checked every cycle against a byte-level model of L / L^-1.
module tb_l_transform_engine;
    import kuz_pkg::*;

    localparam int NDUT = 3;
    localparam logic [127:0] V_PT = 128'h64a59400000000000000000000000000;
    localparam logic [127:0] V_CT = 128'hd456584dd0e3e84cc3166e4b7fa2890d;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_mode;
    logic [127:0] in_data;
    logic         out_ready;

    logic [NDUT-1:0] in_ready_w;
    logic [NDUT-1:0] out_valid_w;
    logic [NDUT-1:0] busy_w;
    logic [127:0]    out_data_w [NDUT];

    logic [127:0] rs_in, rs_fwd, rs_inv;

    int checks;
    int errors;
    int coef [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};
    int lat_exp [NDUT] = '{17, 5, 2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic int m_mul(input int a, input int b);
        int p;
        p = 0;
        while (b != 0) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 'h1C3;
            b = b >> 1;
        end
        return p;
    endfunction

    // Byte list a[0]=a15 .. a[15]=a0; sixteen R (or R^-1) steps.
    function automatic logic [127:0] model_L(input logic [127:0] d, input logic m);
        int a [16];
        int t [16];
        int l;
        logic [127:0] r;
        for (int j = 0; j < 16; j++) a[j] = int'(d[127-8*j -: 8]);
        for (int s = 0; s < 16; s++) begin
            l = 0;
            if (!m) begin
                for (int j = 0; j < 16; j++) l = l ^ m_mul(coef[j], a[j]);
                t[0] = l;
                for (int j = 1; j < 16; j++) t[j] = a[j-1];
            end else begin
                for (int j = 0; j < 16; j++) l = l ^ m_mul(coef[j], a[(j+1) % 16]);
                for (int j = 0; j < 15; j++) t[j] = a[j+1];
                t[15] = l;
            end
            a = t;
        end
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = a[j][7:0];
        return r;
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    kuz_r_step u_rs_fwd (.mode_i(MODE_FWD), .data_i(rs_in),  .data_o(rs_fwd));
    kuz_r_step u_rs_inv (.mode_i(MODE_INV), .data_i(rs_fwd), .data_o(rs_inv));

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int RPC = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
            localparam int NIT = 16 / RPC;

            l_transform_engine #(.ROUNDS_PER_CYCLE(RPC)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready_w[gi]),
                .in_mode   (in_mode),
                .in_data   (in_data),
                .out_valid (out_valid_w[gi]),
                .out_ready (out_ready),
                .out_data  (out_data_w[gi]),
                .busy      (busy_w[gi])
            );

            // Model: a block is pending from acceptance until delivered; result due after NIT cycles.
            initial begin
                bit pending;
                bit zero;
                bit e_valid;
                bit e_ready;
                int left;
                logic [127:0] exp_d;
                pending = 1'b0;
                zero    = 1'b1;
                left    = 0;
                exp_d   = '0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        chk($sformatf("dut%0d rst out_valid", gi), 128'(out_valid_w[gi]), 128'd0);
                        chk($sformatf("dut%0d rst busy", gi), 128'(busy_w[gi]), 128'd0);
                        chk($sformatf("dut%0d rst in_ready", gi), 128'(in_ready_w[gi]), 128'd1);
                        chk($sformatf("dut%0d rst out_data", gi), out_data_w[gi], 128'd0);
                        pending = 1'b0;
                        zero    = 1'b1;
                        left    = 0;
                    end else begin
                        e_valid = pending && (left == 0);
                        e_ready = !pending || (e_valid && out_ready);
                        chk($sformatf("dut%0d busy", gi), 128'(busy_w[gi]), 128'(pending));
                        chk($sformatf("dut%0d out_valid", gi), 128'(out_valid_w[gi]), 128'(e_valid));
                        chk($sformatf("dut%0d in_ready", gi), 128'(in_ready_w[gi]), 128'(e_ready));
                        if (e_valid) begin
                            chk($sformatf("dut%0d out_data", gi), out_data_w[gi], exp_d);
                        end else if (!pending && zero) begin
                            chk($sformatf("dut%0d idle out_data", gi), out_data_w[gi], 128'd0);
                        end
                        if (in_valid && e_ready) begin
                            pending = 1'b1;
                            left    = NIT;
                            exp_d   = model_L(in_data, in_mode);
                            zero    = 1'b0;
                        end else if (e_valid && out_ready) begin
                            pending = 1'b0;
                        end else if (pending && left > 0) begin
                            left--;
                        end
                    end
                end
            end
        end
    endgenerate

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [127:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        step();
        in_valid = 1'b0;
        in_data  = rnd();
        in_mode  = 1'($urandom_range(1));
    endtask

    task automatic collect(output logic [127:0] res [NDUT], output int lat [NDUT]);
        bit [NDUT-1:0] seen;
        seen = '0;
        for (int i = 0; i < NDUT; i++) begin
            res[i] = '0;
            lat[i] = -1;
        end
        for (int c = 1; c <= 40 && seen != '1; c++) begin
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) begin
                if (!seen[i] && out_valid_w[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = c;
                    res[i]  = out_data_w[i];
                    $display("xfer dut%0d lat=%0d out=%h", i, c, out_data_w[i]);
                end
            end
            step();
            in_data = rnd();
        end
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d result timeout", i), 128'(seen[i]), 128'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [127:0] res  [NDUT];
        logic [127:0] res2 [NDUT];
        int           lat  [NDUT];
        logic [127:0] r;
        logic         m;
        bit           saw;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rs_in     = 128'h100;
        repeat (3) step();
        rst = 1'b0;

        chk("rstep fwd", rs_fwd, 128'h94000000000000000000000000000001);
        chk("rstep inv", rs_inv, 128'h100);
        chk("model fwd", model_L(V_PT, 1'b0), V_CT);
        chk("model inv", model_L(V_CT, 1'b1), V_PT);

        // Input wiggle without in_valid must not start anything.
        repeat (4) begin
            in_data = rnd();
            in_mode = 1'($urandom_range(1));
            step();
        end

        launch(V_PT, 1'b0);
        collect(res, lat);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d fwd vec", i), res[i], V_CT);
            chk($sformatf("dut%0d fwd lat", i), 128'(lat[i]), 128'(lat_exp[i]));
        end

        launch(V_CT, 1'b1);
        collect(res, lat);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d inv vec", i), res[i], V_PT);
            chk($sformatf("dut%0d inv lat", i), 128'(lat[i]), 128'(lat_exp[i]));
        end

        // Stall in DONE, then back-to-back accept on the cycle out_ready rises.
        out_ready = 1'b0;
        launch(V_PT, 1'b0);
        collect(res, lat);
        in_valid = 1'b1;
        in_data  = V_CT;
        in_mode  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall out_valid", 128'(out_valid_w), 128'(3'b111));
            chk("stall in_ready", 128'(in_ready_w), 128'd0);
            for (int i = 0; i < NDUT; i++) chk($sformatf("dut%0d stall data", i), out_data_w[i], V_CT);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b in_ready", 128'(in_ready_w), 128'(3'b111));
        step();
        in_valid = 1'b0;
        collect(res, lat);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("dut%0d b2b vec", i), res[i], V_PT);
            chk($sformatf("dut%0d b2b lat", i), 128'(lat[i]), 128'(lat_exp[i]));
        end

        // Reset in the 8th RUN cycle discards the block.
        launch(rnd(), 1'b0);
        repeat (7) step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrun rst data", out_data_w[0], 128'd0);
        step();
        rst = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw = saw | out_valid_w[0];
            step();
        end
        chk("discarded block valid", 128'(saw), 128'd0);
        launch(V_PT, 1'b0);
        collect(res, lat);
        for (int i = 0; i < NDUT; i++) chk($sformatf("dut%0d post-rst vec", i), res[i], V_CT);

        // Round trips on random blocks: L^-1(L(x)) == x and vice versa.
        for (int k = 0; k < 4; k++) begin
            r = rnd();
            m = 1'(k & 1);
            launch(r, m);
            collect(res, lat);
            for (int i = 0; i < NDUT; i++) chk($sformatf("dut%0d rt fwd", i), res[i], model_L(r, m));
            launch(res[0], !m);
            collect(res2, lat);
            for (int i = 0; i < NDUT; i++) chk($sformatf("dut%0d rt back", i), res2[i], r);
        end

        // Random handshake traffic; checked by the per-cycle model.
        repeat (80) begin
            in_valid  = 1'($urandom_range(1));
            in_mode   = 1'($urandom_range(1));
            in_data   = rnd();
            out_ready = ($urandom_range(3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l_transform_engine.md
L_TRANSFORM_ENGINE -- requirements
Module: l_transform_engine

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1; number of R-steps applied per clock; SHALL be one of 1, 2, 4, 8, 16.
REQ-002 Derived constant N_ITER = 16 / ROUNDS_PER_CYCLE; number of compute cycles per block.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_data and in_mode are valid this cycle.
REQ-006 in_ready  output  1  engine accepts a block this cycle.
REQ-007 in_mode  input  1  0 = forward L, 1 = inverse L^-1.
REQ-008 in_data  input  128  block; byte a15 = bits [127:120], a0 = bits [7:0].
REQ-009 out_valid  output  1  out_data holds a finished result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  128  transformed block.
REQ-012 busy  output  1  high in RUN and DONE states.

Function
REQ-013 All arithmetic SHALL be in GF(2^8) with polynomial x^8+x^7+x^6+x+1 (0x1C3); multiplication by 194 SHALL give 1->194, 2->71, 255->10.
REQ-014 Linear form l(a15..a0) = 148*a15 ^ 32*a14 ^ 133*a13 ^ 16*a12 ^ 194*a11 ^ 192*a10 ^ 1*a9 ^ 251*a8 ^ 1*a7 ^ 192*a6 ^ 194*a5 ^ 16*a4 ^ 133*a3 ^ 32*a2 ^ 148*a1 ^ 1*a0.
REQ-015 Forward step R: new a15 = l(a15..a0); new a14..a0 = old a15..a1.
REQ-016 Inverse step R^-1: new a15..a1 = old a14..a0; new a0 = l(a14,a13,..,a0,a15).
REQ-017 FSM states: IDLE, RUN, DONE; single data register, single mode register, iteration counter of width clog2(N_ITER) (minimum 1 bit).
REQ-018 in_ready SHALL be 1 in IDLE, and in DONE when out_ready is 1; 0 in RUN.
REQ-019 On in_valid && in_ready: data <= in_data, mode <= in_mode, counter <= 0, state <= RUN.
REQ-020 In RUN, each cycle: data <= ROUNDS_PER_CYCLE chained steps of the latched mode applied to data; counter increments; after the N_ITER-th update, state <= DONE.
REQ-021 out_valid = 1 exactly in DONE; out_data = data register, held stable while out_valid && !out_ready.
REQ-022 In DONE, out_ready without accepted input -> IDLE; out_ready with accepted input (back-to-back) -> RUN with the new block, no idle cycle.
REQ-023 Latency: out_valid first high N_ITER+1 cycles after the accepting edge; throughput one block per N_ITER+1 cycles.
REQ-024 in_mode and in_data changes SHALL have no effect outside an accepting cycle.
REQ-025 out_data SHALL show the data register in all states; its value outside DONE has no meaning to the consumer.

Reset
REQ-026 rst asserted SHALL immediately force state IDLE, data 0, mode 0, counter 0; hence out_valid 0, busy 0, in_ready 1 after release, out_data 0.
REQ-027 Reset during RUN or DONE SHALL discard the block in flight with no result output.

Structure
REQ-028 Shared package kuz_pkg SHALL hold the polynomial constant, the 16-entry l-coefficient array, the GF(2^8) multiply function and the mode encoding.
REQ-029 Sub-module kuz_r_step (combinational, 128-bit in/out, mode input) SHALL implement one R or R^-1 step; the engine chains ROUNDS_PER_CYCLE instances via generate.
REQ-030 No lookup-table ROMs; all constant products derived from the package function.

Verification
REQ-031 RPC=1, mode 0, in 00000000000000000000000000000100 with one R-step checked in kuz_r_step -> 94000000000000000000000000000001; inverse step on that -> original.
REQ-032 RPC=1, mode 0, in 64a59400000000000000000000000000, out_ready=1 -> out d456584dd0e3e84cc3166e4b7fa2890d with out_valid exactly 17 cycles after acceptance.
REQ-033 mode 1, in d456584dd0e3e84cc3166e4b7fa2890d -> out 64a59400000000000000000000000000.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, out_data unchanged, in_ready 0; then back-to-back second block accepted on the same cycle out_ready rises.
REQ-035 rst pulsed at cycle 8 of RUN -> out_valid never rises for that block, out_data 0, next block processes correctly.
REQ-036 Repeat REQ-032/033 for RPC = 4 and 16 -> identical results, out_valid at 5 and 2 cycles after acceptance respectively.
